// File: rtl/c7bbiu_wr_buf_pkg.sv
// Shared BIU write-path types: AXI IDs, response codes and the buffered store entry.
// Used by the write buffer and the write arbiter.
package c7bbiu_wr_buf_pkg;

    localparam logic [3:0] AXI_WID_LSU     = 4'h1;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

    localparam int WB_ENTRY_W = 68;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wb_entry_t;

    // Exclusive-okay is not expected on plain LSU stores, so it is reported as an error too.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/c7bbiu_sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; head is read combinationally.
// Latency: one cycle push-to-visible; push is ignored when full, pop ignored when empty.
module c7bbiu_sync_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en;
    logic             pop_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Full blocks a push even when a pop lands in the same cycle.
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/c7bbiu_wr_buf.sv
// In-order LSU store buffer feeding c7bbiu_wr_arb; tracks outstanding AXI writes via B.
// Latency: push in cycle N can issue in N+1; LSU stalls when full, issue stalls at OST_MAX.
module c7bbiu_wr_buf
    import c7bbiu_wr_buf_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int OST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_wb_req,
    output logic        lsu_wb_ack,
    input  logic [31:0] lsu_wb_addr,
    input  logic [31:0] lsu_wb_data,
    input  logic [3:0]  lsu_wb_strb,
    output logic        wb_biu_wr_req,
    input  logic        biu_wb_wr_ack,
    output logic [31:0] wb_biu_wr_addr,
    output logic [31:0] wb_biu_wr_data,
    output logic [3:0]  wb_biu_wr_strb,
    output logic        wb_biu_wr_last,
    input  logic        axi_b_valid,
    input  logic [3:0]  axi_b_id,
    input  logic [1:0]  axi_b_resp,
    output logic        axi_b_ready,
    output logic        wb_idle,
    output logic        wb_berr,
    output logic [3:0]  wb_ost_cnt
);

    localparam logic [3:0] OST_MAX_C = 4'(OST_MAX);

    wb_entry_t  push_dat;
    wb_entry_t  head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       wr_pop;
    logic       b_hs;
    logic       underflow;
    logic [3:0] ost_cnt_q, ost_cnt_d;
    logic       berr_q, berr_d;

    assign push_dat   = '{addr: lsu_wb_addr, data: lsu_wb_data, strb: lsu_wb_strb};
    assign lsu_wb_ack = lsu_wb_req & ~fifo_full;

    c7bbiu_sync_fifo #(
        .WIDTH (WB_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (lsu_wb_ack),
        .push_dat_i (push_dat),
        .pop_i      (wr_pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign wb_biu_wr_req  = ~fifo_empty & (ost_cnt_q < OST_MAX_C);
    assign wb_biu_wr_addr = head.addr;
    assign wb_biu_wr_data = head.data;
    assign wb_biu_wr_strb = head.strb;
    assign wb_biu_wr_last = 1'b1;

    // An arbiter ack while req is low does not pop.
    assign wr_pop = wb_biu_wr_req & biu_wb_wr_ack;

    assign axi_b_ready = 1'b1;
    assign b_hs        = axi_b_valid & (axi_b_id == AXI_WID_LSU);
    assign underflow   = b_hs & (ost_cnt_q == 4'd0);

    always_comb begin
        ost_cnt_d = ost_cnt_q;
        berr_d    = 1'b0;
        case ({wr_pop, b_hs})
            2'b10: ost_cnt_d = ost_cnt_q + 4'd1;
            2'b01: begin
                // A response with nothing outstanding is stale; hold at zero and flag it.
                if (!underflow) begin
                    ost_cnt_d = ost_cnt_q - 4'd1;
                end
            end
            default: ost_cnt_d = ost_cnt_q;
        endcase
        berr_d = b_hs & (resp_is_err(axi_b_resp) | underflow);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ost_cnt_q <= 4'd0;
            berr_q    <= 1'b0;
        end else begin
            ost_cnt_q <= ost_cnt_d;
            berr_q    <= berr_d;
        end
    end

    assign wb_idle    = fifo_empty & (ost_cnt_q == 4'd0);
    assign wb_berr    = berr_q;
    assign wb_ost_cnt = ost_cnt_q;

endmodule

// File: tb/tb_c7bbiu_wr_buf.sv
// Bench for c7bbiu_wr_buf: directed scenarios then random traffic against a queue-based model.
module tb_c7bbiu_wr_buf;
    import c7bbiu_wr_buf_pkg::*;

    localparam int DEPTH   = 4;
    localparam int OST_MAX = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_wb_req;
    logic        lsu_wb_ack;
    logic [31:0] lsu_wb_addr;
    logic [31:0] lsu_wb_data;
    logic [3:0]  lsu_wb_strb;
    logic        wb_biu_wr_req;
    logic        biu_wb_wr_ack;
    logic [31:0] wb_biu_wr_addr;
    logic [31:0] wb_biu_wr_data;
    logic [3:0]  wb_biu_wr_strb;
    logic        wb_biu_wr_last;
    logic        axi_b_valid;
    logic [3:0]  axi_b_id;
    logic [1:0]  axi_b_resp;
    logic        axi_b_ready;
    logic        wb_idle;
    logic        wb_berr;
    logic [3:0]  wb_ost_cnt;

    always #5 clk = ~clk;

    c7bbiu_wr_buf #(.DEPTH(DEPTH), .OST_MAX(OST_MAX)) dut (
        .clk            (clk),
        .reset          (reset),
        .lsu_wb_req     (lsu_wb_req),
        .lsu_wb_ack     (lsu_wb_ack),
        .lsu_wb_addr    (lsu_wb_addr),
        .lsu_wb_data    (lsu_wb_data),
        .lsu_wb_strb    (lsu_wb_strb),
        .wb_biu_wr_req  (wb_biu_wr_req),
        .biu_wb_wr_ack  (biu_wb_wr_ack),
        .wb_biu_wr_addr (wb_biu_wr_addr),
        .wb_biu_wr_data (wb_biu_wr_data),
        .wb_biu_wr_strb (wb_biu_wr_strb),
        .wb_biu_wr_last (wb_biu_wr_last),
        .axi_b_valid    (axi_b_valid),
        .axi_b_id       (axi_b_id),
        .axi_b_resp     (axi_b_resp),
        .axi_b_ready    (axi_b_ready),
        .wb_idle        (wb_idle),
        .wb_berr        (wb_berr),
        .wb_ost_cnt     (wb_ost_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the buffer is a queue of stores, outstanding writes a plain count.
    logic [67:0] m_q[$];
    int          m_ost  = 0;
    bit          m_berr = 1'b0;
    int          pop_seen = 0;
    bit          last_ack;
    bit          acks[5];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit req, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit wack, input bit bv,
                        input logic [3:0] bid, input logic [1:0] br);
        bit          m_full, m_req, m_ack, m_pop, m_bcnt;
        logic [67:0] tmp;
        @(negedge clk);
        reset         = rst;
        lsu_wb_req    = req;
        lsu_wb_addr   = a;
        lsu_wb_data   = d;
        lsu_wb_strb   = s;
        biu_wb_wr_ack = wack;
        axi_b_valid   = bv;
        axi_b_id      = bid;
        axi_b_resp    = br;
        #1;
        m_full = (m_q.size() == DEPTH);
        m_req  = (m_q.size() != 0) && (m_ost < OST_MAX);
        m_ack  = req && !m_full;
        m_pop  = m_req && wack;
        m_bcnt = bv && (bid == AXI_WID_LSU);
        check("ack",     64'(lsu_wb_ack),     64'(m_ack));
        check("req",     64'(wb_biu_wr_req),  64'(m_req));
        check("idle",    64'(wb_idle),        64'(m_q.size() == 0 && m_ost == 0));
        check("ost",     64'(wb_ost_cnt),     64'(m_ost));
        check("berr",    64'(wb_berr),        64'(m_berr));
        check("b_ready", 64'(axi_b_ready),    64'(1));
        check("last",    64'(wb_biu_wr_last), 64'(1));
        if (m_req) begin
            check("head_addr", 64'(wb_biu_wr_addr), 64'(m_q[0][67:36]));
            check("head_data", 64'(wb_biu_wr_data), 64'(m_q[0][35:4]));
            check("head_strb", 64'(wb_biu_wr_strb), 64'(m_q[0][3:0]));
        end
        last_ack = lsu_wb_ack;
        if (wb_biu_wr_req && wack) pop_seen++;
        if (rst) begin
            m_q.delete();
            m_ost  = 0;
            m_berr = 1'b0;
        end else begin
            m_berr = m_bcnt && (br != 2'b00 || m_ost == 0);
            if (m_pop && !m_bcnt) m_ost++;
            else if (!m_pop && m_bcnt && m_ost > 0) m_ost--;
            if (m_pop) tmp = m_q.pop_front();
            if (m_ack) m_q.push_back({a, d, s});
        end
    endtask

    task automatic idle(input bit wack);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, wack, 1'b0, 4'h0, 2'b00);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit wack);
        step(1'b0, 1'b1, a, d, s, wack, 1'b0, 4'h0, 2'b00);
    endtask

    task automatic bresp(input logic [3:0] bid, input logic [1:0] br, input bit wack);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, wack, 1'b1, bid, br);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (m_q.size() == 0 && m_ost == 0 && !m_berr) break;
            step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, (m_ost > 0), AXI_WID_LSU, AXI_RESP_OKAY);
        end
        idle(1'b0);
        check("drain_idle", 64'(wb_idle), 64'(1));
    endtask

    initial begin
        reset = 1'b1; lsu_wb_req = 1'b0; lsu_wb_addr = '0; lsu_wb_data = '0; lsu_wb_strb = '0;
        biu_wb_wr_ack = 1'b0; axi_b_valid = 1'b0; axi_b_id = '0; axi_b_resp = '0;
        repeat (2) @(posedge clk);

        // Reset state
        idle(1'b0);
        check("rst_req",  64'(wb_biu_wr_req), 64'(0));
        check("rst_idle", 64'(wb_idle),       64'(1));

        // Single store with a three-cycle arbiter stall
        push(32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check("ss_req",  64'(wb_biu_wr_req),  64'(1));
            check("ss_addr", 64'(wb_biu_wr_addr), 64'h1000_0010);
            check("ss_data", 64'(wb_biu_wr_data), 64'hDEAD_BEEF);
        end
        idle(1'b1);
        idle(1'b0);
        check("ss_ost1", 64'(wb_ost_cnt), 64'(1));
        bresp(AXI_WID_LSU, AXI_RESP_OKAY, 1'b0);
        idle(1'b0);
        check("ss_ost0", 64'(wb_ost_cnt), 64'(0));
        check("ss_idle", 64'(wb_idle),    64'(1));

        // Fill to DEPTH, then a refused push concurrent with a pop
        for (int i = 0; i < 5; i++) begin
            push(32'h2000_0000 + 32'(i * 4), $urandom, 4'(i + 1), 1'b0);
            acks[i] = last_ack;
        end
        check("fill_ack0", 64'(acks[0]), 64'(1));
        check("fill_ack3", 64'(acks[3]), 64'(1));
        check("fill_ack4", 64'(acks[4]), 64'(0));
        push(32'h2000_0100, 32'h1234_5678, 4'h3, 1'b1);
        check("fill_pop_push", 64'(last_ack), 64'(0));
        push(32'h2000_0100, 32'h1234_5678, 4'h3, 1'b0);
        check("fill_after", 64'(last_ack), 64'(1));
        drain();

        // Outstanding limit
        pop_seen = 0;
        for (int i = 0; i < 4; i++) push(32'h3000_0000 + 32'(i * 4), $urandom, 4'hF, 1'b1);
        repeat (3) idle(1'b1);
        check("ol_pops", 64'(pop_seen),      64'(2));
        check("ol_ost",  64'(wb_ost_cnt),    64'(2));
        check("ol_req",  64'(wb_biu_wr_req), 64'(0));
        pop_seen = 0;
        bresp(AXI_WID_LSU, AXI_RESP_OKAY, 1'b1);
        repeat (3) idle(1'b1);
        check("ol_one_more", 64'(pop_seen), 64'(1));
        drain();

        // Pop and B together, then a B for another ID
        push(32'h4000_0000, 32'hAAAA_0001, 4'h1, 1'b1);
        idle(1'b1);
        push(32'h4000_0004, 32'hAAAA_0002, 4'h2, 1'b0);
        bresp(AXI_WID_LSU, AXI_RESP_OKAY, 1'b1);
        idle(1'b0);
        check("pb_ost", 64'(wb_ost_cnt), 64'(1));
        bresp(~AXI_WID_LSU, AXI_RESP_OKAY, 1'b0);
        idle(1'b0);
        check("wid_ost", 64'(wb_ost_cnt), 64'(1));

        // Error response, then an underflowing response
        bresp(AXI_WID_LSU, AXI_RESP_SLVERR, 1'b0);
        idle(1'b0);
        check("err_berr", 64'(wb_berr),    64'(1));
        check("err_ost",  64'(wb_ost_cnt), 64'(0));
        idle(1'b0);
        check("err_pulse", 64'(wb_berr), 64'(0));
        bresp(AXI_WID_LSU, AXI_RESP_OKAY, 1'b0);
        idle(1'b0);
        check("uf_berr", 64'(wb_berr),    64'(1));
        check("uf_ost",  64'(wb_ost_cnt), 64'(0));
        idle(1'b0);
        check("uf_pulse", 64'(wb_berr), 64'(0));

        // Reset with three entries buffered and two outstanding
        push(32'h5000_0000, 32'h1, 4'hF, 1'b1);
        push(32'h5000_0004, 32'h2, 4'hF, 1'b1);
        push(32'h5000_0008, 32'h3, 4'hF, 1'b1);
        push(32'h5000_000C, 32'h4, 4'hF, 1'b0);
        push(32'h5000_0010, 32'h5, 4'hF, 1'b0);
        check("pre_rst_ost", 64'(wb_ost_cnt), 64'(2));
        step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'b00);
        idle(1'b1);
        check("mr_req",  64'(wb_biu_wr_req), 64'(0));
        check("mr_idle", 64'(wb_idle),       64'(1));
        check("mr_ost",  64'(wb_ost_cnt),    64'(0));

        // Random traffic; model keeps checking head fields so stale entries would show
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] br;
            br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : AXI_RESP_OKAY;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6), $urandom, $urandom,
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
                 4'($urandom_range(0, 1)), br);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c7bbiu_wr_buf.md
Name: c7bbiu_wr_buf

Overview:
Write buffer directly upstream of c7bbiu_wr_arb in the BIU. Accepts single-word LSU stores into an in-order FIFO and presents the head entry to the arbiter's request/ack interface. Consumes the AXI B channel to track outstanding writes. Reports idle status (for fences/uncached ordering) and bus write errors back to the LSU.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, minimum 2.
OST_MAX, 4, maximum issued-but-unacknowledged AXI writes; range 1..15.

Ports:
clk  input  1  core clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
lsu_wb_req  input  1  LSU store request.
lsu_wb_ack  output  1  store accepted this cycle (combinational).
lsu_wb_addr  input  32  store byte address.
lsu_wb_data  input  32  store data.
lsu_wb_strb  input  4  byte enables.
wb_biu_wr_req  output  1  head entry valid and issuable; drives lsu_biu_wr_req of c7bbiu_wr_arb.
biu_wb_wr_ack  input  1  arbiter accepted the head (biu_lsu_wr_ack).
wb_biu_wr_addr  output  32  head address.
wb_biu_wr_data  output  32  head data.
wb_biu_wr_strb  output  4  head strobes.
wb_biu_wr_last  output  1  always 1 (single-beat writes).
axi_b_valid  input  1  AXI write response valid.
axi_b_id  input  4  AXI write response ID.
axi_b_resp  input  2  AXI write response code.
axi_b_ready  output  1  B channel ready.
wb_idle  output  1  FIFO empty and no outstanding writes.
wb_berr  output  1  one-cycle pulse on an error response.
wb_ost_cnt  output  4  current outstanding-write count (debug/verification).

Behaviour:
- Reset (clk edge with reset=1): wr_ptr=rd_ptr=0, ost_cnt=0, wb_berr=0. Outputs then: wb_biu_wr_req=0, wb_idle=1, axi_b_ready=1, lsu_wb_ack=lsu_wb_req. Storage array is not reset.
- Pointers are log2(DEPTH)+1 bits. The extra MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = MSB differs and low bits equal.
- Push: lsu_wb_ack = lsu_wb_req & ~full. On ack, write {addr, data, strb} at wr_ptr and increment wr_ptr.
  - Full blocks push even if a pop occurs in the same cycle. No bypass.
- Latency: a store pushed in cycle N can raise wb_biu_wr_req in cycle N+1 at the earliest.
- Issue: wb_biu_wr_req = ~empty & (ost_cnt < OST_MAX).
  - Head fields come combinationally from the entry at rd_ptr, and are held stable while req=1 and ack=0.
  - When req=0, head fields are don't-care.
- Pop: on wb_biu_wr_req & biu_wb_wr_ack, increment rd_ptr. An ack arriving while req=0 is ignored.
- Simultaneous push and pop when neither empty nor full: both occur; occupancy is unchanged.
- B channel: axi_b_ready is constantly 1. A B handshake counts only when axi_b_id == AXI_WID_LSU.
- ost_cnt update:
  - +1 on pop.
  - −1 on a counted B handshake.
  - Both in the same cycle: unchanged.
  - A counted B arriving with ost_cnt==0 leaves the count at 0 (no underflow) and raises wb_berr.
- wb_berr is registered and asserted the cycle after a counted B handshake in either case:
  - axi_b_resp != 2'b00 (OKAY), or
  - the count underflow above.
  - Deasserted otherwise.
- wb_idle = empty & (ost_cnt == 0), combinational.
- Ordering: strictly in-order issue. No merging, no store-to-load forwarding.
- Reset mid-operation: all buffered and outstanding state is discarded. B responses after reset are handled per the underflow rule.

Decomposition:
- Package: AXI_WID_LSU, response codes (AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR), AXI_SIZE_WORD. These go in the existing axi_types include shared with c7bbiu_wr_arb.
- Sub-module c7bbiu_sync_fifo (parameterized WIDTH=68, DEPTH; push/pop/full/empty/head). It is reusable for a future read buffer.
- Outstanding counter and B handling stay in c7bbiu_wr_buf.

Test Plan:
- Single store: addr 0x1000_0010, data 0xDEAD_BEEF, strb 0xF, with wr_ack held 0 for 3 cycles then 1. Required: req rises the cycle after push; fields stable for all 3 stalled cycles; pop on ack; ost_cnt=1; B OKAY → ost_cnt=0 and wb_idle=1 next cycle.
- Fill: 5 back-to-back pushes with DEPTH=4 and wr_ack=0. Required: acks 1,1,1,1,0; full holds; a 5th request concurrent with the first pop is still refused; the next cycle it is accepted.
- Outstanding limit: OST_MAX=2, 4 stores, wr_ack=1, no B. Required: exactly 2 pops, then req=0 with ost_cnt=2; one B → exactly one more issue.
- Simultaneous pop and B with ost_cnt=1. Required: ost_cnt stays 1. Wrong-ID B (id≠AXI_WID_LSU) → no count change.
- Error: B with resp=2'b10 → wb_berr high for exactly 1 cycle and ost_cnt decremented. B with ost_cnt=0 → wb_berr pulse and count stays 0.
- Reset asserted with 3 entries buffered and 2 outstanding. Required: next cycle wb_biu_wr_req=0, wb_idle=1, ost_cnt=0, and no stale entry is ever issued afterward.
